toggle_cover_collector: RTL and testbench
=========================================

TOGGLE_COVER_COLLECTOR -- requirements
Module: toggle_cover_collector

Interface
REQ-001 Parameter WIDTH, default 11, number of monitored signal bits (1..1024).
REQ-002 Parameter COVER_INDEX, default 0, global index of this instance's first cover point.
REQ-003 Parameter COVER_TOTAL, default 38253, total cover points in the design; informational, not used in any logic.
REQ-004 Derived NPTS = 2*WIDTH if TOGGLE_COVER_DIR_EN defined, else WIDTH; CW = clog2(NPTS+1).
REQ-005 gbl_clk  input  1  clock; all state updates on its rising edge.
REQ-006 reset  input  1  reset, synchronous, active-low.
REQ-007 en  input  1  toggle-detection enable.
REQ-008 sig  input  WIDTH  monitored signal vector.
REQ-009 out_valid  output  1  a newly covered point is presented.
REQ-010 out_ready  input  1  consumer accepts the presented point.
REQ-011 out_index  output  64  global index of the presented point.
REQ-012 covered_count  output  CW  number of distinct points hit since reset.
REQ-013 all_covered  output  1  high when covered_count == NPTS.

Function
REQ-014 prev_q SHALL capture sig on every non-reset edge, regardless of en.
REQ-015 primed SHALL be 0 after reset and 1 from the first non-reset edge onward; no toggle is detected while primed == 0.
REQ-016 Bit i toggles at edge k when primed, en, and sig[i] != prev_q[i] are all sampled high at edge k.
REQ-017 With DIR_EN: rise = sig & ~prev_q maps to point 2i; fall = ~sig & prev_q maps to point 2i+1. Without DIR_EN: any toggle of bit i maps to point i.
REQ-018 Bitmap hit_q[NPTS] and pending_q[NPTS]: newly = detected & ~hit_q; at edge k, hit_q |= newly and pending_q |= newly.
REQ-019 covered_count SHALL increase at edge k by popcount(newly); multiple points in one cycle are all counted; the count saturates at NPTS by construction.
REQ-020 Output stage: when out_valid == 0 or (out_valid && out_ready), at the edge the stage SHALL load the lowest-numbered set bit p of pending_q (registered value), set out_index = COVER_INDEX + p, clear pending_q[p], and set out_valid; if pending_q is empty, out_valid SHALL go 0.
REQ-021 Latency: a first toggle at edge k into an idle stage gives out_valid high in the cycle after edge k+1.
REQ-022 While out_valid && !out_ready, out_index and out_valid SHALL hold stable.
REQ-023 A pending bit cleared by a load and new bits set by newly at the same edge SHALL both take effect; no point is lost or duplicated.
REQ-024 Each point SHALL be reported exactly once per reset epoch; later toggles of a hit point are ignored.
REQ-025 out_index arithmetic SHALL be 64-bit unsigned with no truncation of COVER_INDEX.

Reset
REQ-026 When reset == 0 at an edge: out_valid=0, out_index=0, covered_count=0, all_covered=0, hit_q=0, pending_q=0, primed=0, prev_q=0.
REQ-027 Reset asserted mid-operation SHALL discard any presented and pending points; the same points are reported again after reset deasserts.

Configuration
REQ-028 Macro TOGGLE_COVER_DIR_EN: defined -> separate rise/fall points, NPTS=2*WIDTH; undefined -> one any-edge point per bit, NPTS=WIDTH, with no rise/fall logic present.

Verification
REQ-029 WIDTH=11, no DIR_EN, COVER_INDEX=100, out_ready=1; after reset sig: 0 -> 0x001 -> out_index=100 reported once, covered_count=1; further toggles of bit 0 -> no new output.
REQ-030 Same config, out_ready=0; sig changes 0 -> 0x7FF in one cycle -> covered_count=11 the next cycle; then out_ready=1 -> indices 100..110 in ascending order on consecutive cycles, all_covered=1.
REQ-031 DIR_EN, WIDTH=4, COVER_INDEX=0; sig: 0 -> 0x2 -> 0x0 -> outputs 2 (rise) then 3 (fall); covered_count=2.
REQ-032 en=0 while sig toggles 0x0 -> 0xF; then en=1 with sig held -> no output, covered_count stays 0.
REQ-033 First sampled sig=0x5 after reset -> no output (unprimed).
REQ-034 Reset pulled low while out_valid=1 and 3 points pending -> all outputs 0 next cycle; repeating the stimulus re-reports the same indices.

Source files
------------

// File: rtl/toggle_cover_collector.sv
// toggle_cover_collector
//   Toggle-coverage collector. Watches a WIDTH-bit signal vector, records
//   each cover point the first time it toggles, and streams the global
//   index of every newly covered point through a valid/ready output stage.
//
//   Build option: define TOGGLE_COVER_DIR_EN to split every bit into a rise
//   point (2*i) and a fall point (2*i+1). Without it, any edge of bit i hits
//   point i, and no rise/fall logic is built.
//
// Ports
//   gbl_clk        clock, rising edge
//   reset          synchronous reset, active low
//   en             toggle-detection enable
//   sig[WIDTH]     monitored vector
//   out_valid      a newly covered point is presented
//   out_ready      consumer accepts the presented point
//   out_index[64]  COVER_INDEX + local point number
//   covered_count  distinct points hit since reset
//   all_covered    covered_count == NPTS
module toggle_cover_collector #(
  parameter int          WIDTH       = 11,
  parameter logic [63:0] COVER_INDEX = 64'd0,
  parameter int          COVER_TOTAL = 38253,
`ifdef TOGGLE_COVER_DIR_EN
  localparam int NPTS = 2 * WIDTH,
`else
  localparam int NPTS = WIDTH,
`endif
  localparam int CW = $clog2(NPTS + 1)
) (
  input  logic             gbl_clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] sig,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_index,
  output logic [CW-1:0]    covered_count,
  output logic             all_covered
);

  localparam int IW = (NPTS > 1) ? $clog2(NPTS) : 1;

  logic [WIDTH-1:0] prev_q;
  logic             primed;
  logic [NPTS-1:0]  detected, newly, hit_q, pending_q, take;
  logic [CW-1:0]    new_cnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_found;
  logic             load;
  logic             arm;

  // COVER_TOTAL is informational only; this empty guard just keeps it
  // referenced so the parameter stays visible on every instance.
  if (COVER_TOTAL < 0) begin : g_total_info
  end

  assign arm = primed & en;

  // Per-bit edge detection into cover points.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
`ifdef TOGGLE_COVER_DIR_EN
    assign detected[2*i]   = arm &  sig[i] & ~prev_q[i];
    assign detected[2*i+1] = arm & ~sig[i] &  prev_q[i];
`else
    assign detected[i]     = arm & (sig[i] ^ prev_q[i]);
`endif
  end

  // Already-hit points are ignored for the rest of the reset epoch.
  assign newly = detected & ~hit_q;

  always_comb begin
    new_cnt = '0;
    for (int i = 0; i < NPTS; i++)
      new_cnt = new_cnt + CW'(newly[i]);
  end

  // Lowest-numbered pending point; scanning downward leaves the lowest.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = NPTS - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(i);
      end
    end
  end

  // The output register is free when empty or being accepted this cycle.
  assign load = ~out_valid | out_ready;
  assign take = (load && pick_found) ? (NPTS'(1) << pick_idx) : '0;

  always_ff @(posedge gbl_clk) begin
    if (!reset) begin
      prev_q        <= '0;
      primed        <= 1'b0;
      hit_q         <= '0;
      pending_q     <= '0;
      covered_count <= '0;
      out_valid     <= 1'b0;
      out_index     <= '0;
    end else begin
      prev_q        <= sig;
      primed        <= 1'b1;
      hit_q         <= hit_q | newly;
      // A newly hit point can never be the one being taken (it was not yet
      // hit, so it cannot be pending), so clear-then-set loses nothing.
      pending_q     <= (pending_q & ~take) | newly;
      covered_count <= covered_count + new_cnt;
      if (load) begin
        out_valid <= pick_found;
        if (pick_found)
          out_index <= COVER_INDEX + 64'(pick_idx);
      end
    end
  end

  assign all_covered = (covered_count == CW'(NPTS));

endmodule

// File: tb/tb_toggle_cover_collector.sv
module tb_toggle_cover_collector;

  localparam int          WIDTH = 11;
  localparam logic [63:0] CIDX  = 64'd100;
`ifdef TOGGLE_COVER_DIR_EN
  localparam int NPTS = 2 * WIDTH;
`else
  localparam int NPTS = WIDTH;
`endif
  localparam int CW = $clog2(NPTS + 1);

  logic             gbl_clk = 1'b0;
  logic             reset = 1'b0;
  logic             en = 1'b0;
  logic [WIDTH-1:0] sig = '0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [63:0]      out_index;
  logic [CW-1:0]    covered_count;
  logic             all_covered;

  int n_checks = 0;
  int n_fail   = 0;

  toggle_cover_collector #(
    .WIDTH(WIDTH), .COVER_INDEX(CIDX), .COVER_TOTAL(38253)
  ) dut (
    .gbl_clk(gbl_clk), .reset(reset), .en(en), .sig(sig),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .covered_count(covered_count), .all_covered(all_covered)
  );

  always #5 gbl_clk = ~gbl_clk;

  // Behavioural model: sets of hit and pending points, one presented slot.
  logic [WIDTH-1:0] m_prev;
  bit               m_primed;
  bit               m_hit  [NPTS];
  bit               m_pend [NPTS];
  bit               m_valid;
  logic [63:0]      m_idx;
  int               m_count;

  function automatic int pt(int b, bit rise);
`ifdef TOGGLE_COVER_DIR_EN
    return rise ? 2*b : 2*b + 1;
`else
    return b;
`endif
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int  fresh[$];
    bit  found;
    if (!reset) begin
      m_prev = '0; m_primed = 0; m_valid = 0; m_idx = '0; m_count = 0;
      for (int p = 0; p < NPTS; p++) begin m_hit[p] = 0; m_pend[p] = 0; end
      return;
    end
    for (int b = 0; b < WIDTH; b++)
      if (m_primed && en && sig[b] != m_prev[b] && !m_hit[pt(b, sig[b])])
        fresh.push_back(pt(b, sig[b]));
    // Handshake uses the pending set as it stood before this edge.
    if (!m_valid || out_ready) begin
      found = 0;
      for (int p = 0; p < NPTS; p++) begin
        if (!found && m_pend[p]) begin
          found = 1; m_pend[p] = 0; m_idx = CIDX + 64'(p);
        end
      end
      m_valid = found;
    end
    foreach (fresh[j]) begin
      m_hit[fresh[j]] = 1; m_pend[fresh[j]] = 1; m_count++;
    end
    m_prev = sig; m_primed = 1;
  endtask

  // One clock: update the model at the edge, compare just after it.
  task automatic step();
    @(posedge gbl_clk);
    model_edge();
    #1;
    check("valid", 64'(out_valid), 64'(m_valid));
    check("index", out_index, m_idx);
    check("count", 64'(covered_count), 64'(m_count));
    check("allcov", 64'(all_covered), 64'(m_count == NPTS));
  endtask

  task automatic do_reset();
    reset = 1'b0; sig = '0;
    step(); step();
    reset = 1'b1;
  endtask

  initial begin
    do_reset();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_index", out_index, 64'd0);
    check("rst_count", 64'(covered_count), 64'd0);

    // Single toggle, ready high: reported once, later toggles ignored.
    en = 1; out_ready = 1; sig = '0; step();
    sig = 11'h001; step();
    check("t1_count", 64'(covered_count), 64'd1);
    check("t1_notyet", 64'(out_valid), 64'd0);
    step();
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_index", out_index, CIDX + 64'(pt(0, 1)));
    step();
    check("t1_once", 64'(out_valid), 64'd0);
    for (int k = 0; k < 4; k++) begin sig = sig ^ 11'h001; step(); end

    // All bits at once with ready low, then drain in ascending order.
    do_reset();
    en = 1; out_ready = 0; sig = '0; step();
    sig = 11'h7FF; step();
    check("all_count", 64'(covered_count), 64'd11);
    step(); step();
    out_ready = 1;
    for (int j = 0; j < WIDTH; j++) begin
      check("drain_valid", 64'(out_valid), 64'd1);
      check("drain_index", out_index, CIDX + 64'(pt(j, 1)));
      step();
    end
    check("drain_done", 64'(out_valid), 64'd0);
`ifndef TOGGLE_COVER_DIR_EN
    check("all_covered", 64'(all_covered), 64'd1);
`else
    // Rise then fall of one bit gives two distinct points.
    do_reset();
    en = 1; out_ready = 1; sig = '0; step();
    sig = 11'h002; step();
    sig = 11'h000; step();
    check("dir_rise", out_index, CIDX + 64'd2);
    step();
    check("dir_fall", out_index, CIDX + 64'd3);
    check("dir_count", 64'(covered_count), 64'd2);
`endif

    // Toggles with en low are not seen, even once en rises.
    do_reset();
    en = 0; out_ready = 1; sig = '0; step();
    sig = 11'h00F; step();
    en = 1; step(); step(); step();
    check("en_count", 64'(covered_count), 64'd0);
    check("en_valid", 64'(out_valid), 64'd0);

    // First sample after reset only primes.
    do_reset();
    en = 1; sig = 11'h005; step(); step(); step();
    check("prime_count", 64'(covered_count), 64'd0);
    check("prime_valid", 64'(out_valid), 64'd0);

    // Reset with one presented and three pending, then replay.
    for (int rep = 0; rep < 2; rep++) begin
      do_reset();
      en = 1; out_ready = rep[0]; sig = '0; step();
      sig = 11'h00F; step();
      step();
      if (rep == 0) begin
        check("mid_valid", 64'(out_valid), 64'd1);
        reset = 1'b0; step();
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_count", 64'(covered_count), 64'd0);
        check("mid_rst_index", out_index, 64'd0);
      end else begin
        for (int j = 0; j < 4; j++) begin
          check("replay_index", out_index, CIDX + 64'(pt(j, 1)));
          step();
        end
      end
    end

    // Random phase: sparse toggles, random en/ready, occasional reset.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      en        = ($urandom_range(0, 9) < 8);
      out_ready = ($urandom_range(0, 9) < 6);
      sig       = sig ^ WIDTH'($urandom & $urandom & $urandom);
      reset     = ($urandom_range(0, 79) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
